// File: rtl/la_pkg.sv
// Shared constants and types for the logic-analyser acquisition path.
package la_pkg;
  localparam int NUM_CH = 16;
  localparam int WORD_W = 16;
  localparam int DIV_W  = 8;

  typedef logic [NUM_CH-1:0] chan_mask_t;

  typedef enum logic {
    IDLE,
    SCAN
  } scan_state_t;
endpackage

// File: rtl/synchronizer.sv
// Plain two-flop data synchronizer; deliberately unreset since it only carries data.
module synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end
endmodule

// File: rtl/sample_packer.sv
// Samples the probe pins at a programmable rate and packs each 16-sample block
// into one word per enabled channel, emitted in ascending channel order.
module sample_packer #(
  parameter int NUM_CH = 16,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] probe,
  input  logic              acq_enable,
  input  logic [DIV_W-1:0]  clock_divisor,
  input  logic [NUM_CH-1:0] channel_enable,
  output logic [NUM_CH-1:0] sample_data,
  output logic              sample_data_avail
);
  import la_pkg::*;

  localparam int CNT_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] probe_s;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  term;
  logic              strobe;
  logic [CNT_W-1:0]  samp_cnt;
  logic              block_done;
  logic [NUM_CH-1:0] shreg   [NUM_CH];
  logic [NUM_CH-1:0] shifted [NUM_CH];
  logic [NUM_CH-1:0] hold    [NUM_CH];
  chan_mask_t        hold_mask;

  scan_state_t       state, state_n;
  logic [CNT_W-1:0]  ptr, ptr_n;
  logic [NUM_CH-1:0] data_n;
  logic              avail_n;

  synchronizer #(.WIDTH(NUM_CH)) u_probe_sync (
    .clk (clk),
    .d   (probe),
    .q   (probe_s)
  );

  // >= rather than == so a divisor shrinking mid-run cannot miss the wrap.
  assign term       = (clock_divisor == '0) ? '0 : clock_divisor - DIV_W'(1);
  assign strobe     = acq_enable && (div_cnt >= term);
  assign block_done = strobe && (samp_cnt == CNT_W'(NUM_CH - 1));

  always_comb begin
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      shifted[ch] = {probe_s[ch], shreg[ch][NUM_CH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      samp_cnt  <= '0;
      hold_mask <= '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        shreg[ch] <= '0;
        hold[ch]  <= '0;
      end
    end else if (!acq_enable) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (strobe) begin
      div_cnt  <= '0;
      samp_cnt <= samp_cnt + CNT_W'(1);
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        shreg[ch] <= shifted[ch];
        if (block_done) hold[ch] <= shifted[ch];
      end
      if (block_done) hold_mask <= channel_enable;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      ptr               <= '0;
      sample_data       <= '0;
      sample_data_avail <= 1'b0;
    end else begin
      state             <= state_n;
      ptr               <= ptr_n;
      sample_data       <= data_n;
      sample_data_avail <= avail_n;
    end
  end

  // A new block landing in the last scan cycle restarts the scan instead of exiting.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    data_n  = sample_data;
    avail_n = 1'b0;
    if (state == SCAN) begin
      if (hold_mask[ptr]) begin
        data_n  = hold[ptr];
        avail_n = 1'b1;
      end
      ptr_n = ptr + CNT_W'(1);
      if (ptr == CNT_W'(NUM_CH - 1)) state_n = IDLE;
    end
    if (block_done) begin
      state_n = SCAN;
      ptr_n   = '0;
    end
  end
endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer: word values and emission cycles per scenario.
module tb_sample_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] probe = '0;
  logic        acq_enable = 1'b0;
  logic [7:0]  clock_divisor = 8'd1;
  logic [15:0] channel_enable = '0;
  logic [15:0] sample_data;
  logic        sample_data_avail;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [15:0] wq[$];
  int          wc[$];

  sample_packer #(.NUM_CH(16), .DIV_W(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .probe             (probe),
    .acq_enable        (acq_enable),
    .clock_divisor     (clock_divisor),
    .channel_enable    (channel_enable),
    .sample_data       (sample_data),
    .sample_data_avail (sample_data_avail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_data_avail) begin
      wq.push_back(sample_data);
      wc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Word for channel ch when sample j of the block equals base_val + j.
  function automatic logic [15:0] ramp_word(int base_val, int ch);
    logic [15:0] w;
    int v;
    for (int j = 0; j < 16; j++) begin
      v = base_val + j;
      w[j] = v[ch];
    end
    return w;
  endfunction

  task automatic clear_log();
    wq.delete();
    wc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sample_data !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_data: got %h expected %h", sample_data, 16'h0000);
    end
    n_cmp++;
    if (sample_data_avail !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_avail: got %b expected %b", sample_data_avail, 1'b0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_toggle(input logic [7:0] div, input string name);
    int base;
    int exp_cyc[2];
    exp_cyc[0] = 19;
    exp_cyc[1] = 35;
    clear_log();
    clock_divisor  = div;
    channel_enable = 16'h0001;
    base = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) base = cyc;
      probe      = (k % 2 == 0) ? 16'h0001 : 16'h0000;
      acq_enable = (k >= 2 && k < 34);
    end
    acq_enable = 1'b0;
    n_cmp++;
    if (wq.size() !== 2) begin
      n_bad++;
      $display("FAIL %s_count: got %0d expected %0d", name, wq.size(), 2);
    end
    for (int i = 0; i < 2 && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== 16'h5555) begin
        n_bad++;
        $display("FAIL %s_word%0d: got %h expected %h", name, i, wq[i], 16'h5555);
      end
      n_cmp++;
      if (wc[i] - base !== exp_cyc[i]) begin
        n_bad++;
        $display("FAIL %s_cycle%0d: got %0d expected %0d", name, i, wc[i] - base, exp_cyc[i]);
      end
    end
  endtask

  task automatic test_div4();
    int base;
    int exp_cyc[4];
    exp_cyc[0] = 68;
    exp_cyc[1] = 83;
    exp_cyc[2] = 132;
    exp_cyc[3] = 147;
    clear_log();
    clock_divisor  = 8'd4;
    channel_enable = 16'h8001;
    base = 0;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      if (k == 0) base = cyc;
      probe      = 16'hFFFF;
      acq_enable = (k >= 3 && k < 131);
    end
    acq_enable = 1'b0;
    n_cmp++;
    if (wq.size() !== 4) begin
      n_bad++;
      $display("FAIL div4_count: got %0d expected %0d", wq.size(), 4);
    end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== 16'hFFFF) begin
        n_bad++;
        $display("FAIL div4_word%0d: got %h expected %h", i, wq[i], 16'hFFFF);
      end
      n_cmp++;
      if (wc[i] - base !== exp_cyc[i]) begin
        n_bad++;
        $display("FAIL div4_cycle%0d: got %0d expected %0d", i, wc[i] - base, exp_cyc[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [15:0] exp_w;
    clear_log();
    clock_divisor  = 8'd1;
    channel_enable = 16'hFFFF;
    base = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 0) base = cyc;
      probe      = k[15:0];
      acq_enable = (k >= 2 && k < 50);
    end
    acq_enable = 1'b0;
    n_cmp++;
    if (wq.size() !== 48) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d expected %0d", wq.size(), 48);
    end
    for (int i = 0; i < 48 && i < wq.size(); i++) begin
      exp_w = ramp_word(16 * (i / 16), i % 16);
      n_cmp++;
      if (wq[i] !== exp_w) begin
        n_bad++;
        $display("FAIL b2b_word%0d: got %h expected %h", i, wq[i], exp_w);
      end
      n_cmp++;
      if (wc[i] - base !== 19 + i) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d: got %0d expected %0d", i, wc[i] - base, 19 + i);
      end
    end
  endtask

  task automatic test_acq_drop();
    int base;
    clear_log();
    clock_divisor  = 8'd1;
    channel_enable = 16'h0002;
    base = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 0) base = cyc;
      probe      = k[15:0];
      acq_enable = (k >= 2 && k < 12) || (k >= 15 && k < 31);
    end
    acq_enable = 1'b0;
    n_cmp++;
    if (wq.size() !== 1) begin
      n_bad++;
      $display("FAIL drop_count: got %0d expected %0d", wq.size(), 1);
    end
    if (wq.size() >= 1) begin
      n_cmp++;
      if (wq[0] !== 16'h6666) begin
        n_bad++;
        $display("FAIL drop_word: got %h expected %h", wq[0], 16'h6666);
      end
      n_cmp++;
      if (wc[0] - base !== 33) begin
        n_bad++;
        $display("FAIL drop_cycle: got %0d expected %0d", wc[0] - base, 33);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int base;
    int exp_c;
    logic [15:0] exp_w;
    clear_log();
    clock_divisor  = 8'd1;
    channel_enable = 16'hFFFF;
    base = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 0) base = cyc;
      probe      = k[15:0];
      acq_enable = (k >= 2 && k < 40);
      if (k == 24) rst_n = 1'b1;
      if (k == 22) begin
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sample_data !== 16'h0000) begin
          n_bad++;
          $display("FAIL rstmid_data: got %h expected %h", sample_data, 16'h0000);
        end
        n_cmp++;
        if (sample_data_avail !== 1'b0) begin
          n_bad++;
          $display("FAIL rstmid_avail: got %b expected %b", sample_data_avail, 1'b0);
        end
      end
      if (k == 23) begin
        n_cmp++;
        if (sample_data_avail !== 1'b0) begin
          n_bad++;
          $display("FAIL rsthold_avail: got %b expected %b", sample_data_avail, 1'b0);
        end
      end
    end
    acq_enable = 1'b0;
    rst_n = 1'b1;
    n_cmp++;
    if (wq.size() !== 20) begin
      n_bad++;
      $display("FAIL rstmid_count: got %0d expected %0d", wq.size(), 20);
    end
    for (int i = 0; i < 20 && i < wq.size(); i++) begin
      if (i < 4) begin
        exp_w = ramp_word(0, i);
        exp_c = 19 + i;
      end else begin
        exp_w = ramp_word(22, i - 4);
        exp_c = 41 + (i - 4);
      end
      n_cmp++;
      if (wq[i] !== exp_w) begin
        n_bad++;
        $display("FAIL rstmid_word%0d: got %h expected %h", i, wq[i], exp_w);
      end
      n_cmp++;
      if (wc[i] - base !== exp_c) begin
        n_bad++;
        $display("FAIL rstmid_cycle%0d: got %0d expected %0d", i, wc[i] - base, exp_c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_toggle(8'd1, "div1");
    test_toggle(8'd0, "div0");
    test_div4();
    test_back_to_back();
    test_acq_drop();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sample_packer.md
# sample_packer

Fast-clock-domain acquisition front end that samples the 16 probe pins at a programmable rate and packs them into per-channel 16-bit words. It feeds the write side of the sample FIFO: its `sample_data` / `sample_data_avail` outputs drive the FIFO `din` / `wr_en` directly. Its control inputs come from the normal clock domain via the existing synchronizers. Output format: after every 16 samples, one word per enabled channel, in ascending channel order; bit *k* of a word is sample *k* of the block.

## Interface
- `NUM_CH`, 16, number of probe channels, equal to the word width.
- `DIV_W`, 8, width of the clock divisor.
- `clk`  in  1  fast clock (`fastclk`).
- `rst_n`  in  1  asynchronous, active-low reset.
- `probe`  in  16  raw probe pins, asynchronous to `clk`.
- `acq_enable`  in  1  run/stop control, already synchronized to `clk`.
- `clock_divisor`  in  8  sample period in `clk` cycles; value 0 is treated as 1.
- `channel_enable`  in  16  per-channel enable mask.
- `sample_data`  out  16  packed word.
- `sample_data_avail`  out  1  one-cycle write strobe for `sample_data`.

## Operation
- Reset value of every register is 0, including outputs, counters, shift registers, hold registers and the emit state.
- **Probe input**
  - `probe` passes through a 2-flop synchronizer to give `probe_s` (2-cycle latency).
- **Divider**
  - `term = max(clock_divisor,1) - 1`.
  - While `acq_enable` is 0: `div_cnt = 0`.
  - Otherwise the strobe fires when `div_cnt >= term`, and `div_cnt` returns to 0 on the strobe; else `div_cnt` increments.
  - The `>=` compare keeps the wrap safe if the divisor shrinks mid-run.
  - Period 1 means a strobe on every enabled cycle, including the first.
- **Capture**
  - On each strobe, for every channel: `shreg[ch] <= {probe_s[ch], shreg[ch][15:1]}`.
  - `samp_cnt` (4-bit) increments and wraps 15 -> 0.
- **Block complete** (strobe while `samp_cnt == 15`)
  - `hold[ch] <= {probe_s[ch], shreg[ch][15:1]}`.
  - `hold_mask <= channel_enable`.
  - `emitting <= 1`, `ptr <= 0`.
- **Emit** (scan state)
  - Each cycle with `emitting = 1`: if `hold_mask[ptr]`, register `sample_data <= hold[ptr]` and `sample_data_avail <= 1`; otherwise `sample_data_avail <= 0`.
  - `ptr` increments every cycle; `emitting` clears after `ptr == 15`.
  - The scan always takes 16 cycles.
  - `sample_data` holds its last value when not strobed.
- **States:** IDLE (`emitting = 0`) -> SCAN on block complete; SCAN -> IDLE after `ptr == 15`.
  - A block complete arriving in the final SCAN cycle restarts SCAN with `ptr = 0`; restart has priority over the exit.
- **No overrun by construction:** a block needs at least 16 cycles (period >= 1) and a scan takes exactly 16 cycles. No full/overflow handling exists here; FIFO overflow belongs to the FIFO.
- **`acq_enable` falling:** `div_cnt` and `samp_cnt` clear and the partial block is discarded. An in-progress scan runs to completion.
- **`channel_enable == 0`:** blocks still complete, but no words are emitted.
- **Mid-block changes:** `channel_enable` is applied at block completion only.

## Timing
- Pin-to-capture latency is 2 cycles (synchronizer). The strobe cycle captures the `probe_s` present in that cycle.
- If the 16th strobe of a block falls in cycle T, the word for channel *ch* has `sample_data_avail = 1` in cycle T+2+ch.
  - Words for disabled channels leave gaps; they are not compacted in time.
- Back-to-back blocks at period 1 produce a continuous scan: the last word of one block (ch15, T+17) is immediately followed by ch0 of the next block (T+18).
- Asserting `rst_n` low mid-scan aborts immediately; outputs are 0 while reset is held.

## Structure
- **Shared package** `la_pkg`:
  - `NUM_CH = 16`, `WORD_W = 16`, `DIV_W = 8`.
  - The typedef `chan_mask_t` (16-bit).
- **Sub-module:** the existing `synchronizer #(16)` provides the probe synchronizer. It carries no reset, which is acceptable for a data synchronizer.
- **Remainder:** a single always block for divider/capture and one for the scan FSM.

## Test plan
- Divisor 1, `channel_enable = 16'h0001`, `probe[0]` toggling every cycle starting at 1 -> one word per 16 cycles, value 16'h5555 (sample 0 in bit 0 reads 1), strobe in T+2.
- Divisor 4, `channel_enable = 16'h8001`, `probe = 16'hFFFF` constant -> every 64 cycles two words 16'hFFFF, spaced 15 cycles apart (ch0 at T+2, ch15 at T+17).
- Divisor 0 vs 1 -> identical output streams.
- Divisor 1, `channel_enable = 16'hFFFF`, ramp pattern on `probe` -> `sample_data_avail` high every cycle with no gap across block boundaries; per-channel words match the reference model.
- `acq_enable` dropped after 10 strobes, then re-raised -> no word from the partial block. The first new block completes exactly 16 strobes after the re-enable.
- `rst_n` pulsed low during a scan after word 3 -> outputs go to 0 asynchronously, no further words. After release, the first word appears only after a full new 16-sample block.
